// File: rtl/frame_parser_if.sv
// Payload byte stream from frame_parser to its consumer.
// The master drives valid/data/last; the slave answers with ready.
interface frame_parser_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/frame_parser.sv
// Hunts a 19-byte shift window for HDR0/HDR1 + 16 payload bytes + checksum and streams the payload.
// Define FRAME_PARSER_CSUM_EN to check byte 18 against the payload sum; otherwise every candidate is accepted.
module frame_parser #(
    parameter logic [7:0] HDR0 = 8'hA5,
    parameter logic [7:0] HDR1 = 8'h5A
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wen,
    input  logic [151:0]   frame,
    frame_parser_if.master out_if,
    output logic           frame_ok,
    output logic           frame_err,
    output logic [7:0]     err_cnt
);
    typedef enum logic {HUNT = 1'b0, SEND = 1'b1} state_e;

    state_e       state_q, state_d;
    logic [4:0]   fill_q, fill_d;
    logic         wen_d_q, wen_d_d;
    logic [3:0]   idx_q, idx_d;
    logic [127:0] payload_q, payload_d;
    logic         out_valid_q, out_valid_d;
    logic [7:0]   out_data_q, out_data_d;
    logic         out_last_q, out_last_d;
    logic         frame_ok_q, frame_ok_d;
    logic         frame_err_q, frame_err_d;
    logic [7:0]   err_cnt_q, err_cnt_d;

    logic candidate;
    logic csum_ok;

`ifdef FRAME_PARSER_CSUM_EN
    logic [7:0] csum;

    // NOTE: blocking assignments inside always_comb are intended; the sum accumulates within one evaluation.
    always_comb begin
        csum = 8'h00;
        for (int i = 2; i < 18; i++) begin
            csum = csum + frame[8*i +: 8];
        end
    end

    assign csum_ok = (csum == frame[151:144]);
`else
    logic unused_csum_byte;

    assign unused_csum_byte = ^frame[151:144];
    assign csum_ok          = 1'b1;
`endif

    // Only a freshly shifted, completely filled window is ever examined, and only while hunting.
    assign candidate = wen_d_q && (state_q == HUNT) && (fill_q == 5'd19) &&
                       (frame[7:0] == HDR0) && (frame[15:8] == HDR1);

    // NOTE: every signal gets a default at the top so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        wen_d_d     = wen;
        idx_d       = idx_q;
        payload_d   = payload_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (wen && (fill_q != 5'd19)) begin
            fill_d = fill_q + 5'd1;
        end

        unique case (state_q)
            HUNT: begin
                if (candidate) begin
                    if (csum_ok) begin
                        payload_d   = frame[143:16];
                        fill_d      = 5'd0;
                        frame_ok_d  = 1'b1;
                        state_d     = SEND;
                        idx_d       = 4'd0;
                        out_valid_d = 1'b1;
                        out_data_d  = frame[23:16];
                        out_last_d  = 1'b0;
                    end else begin
                        frame_err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                end
            end
            SEND: begin
                if (out_valid_q && out_if.out_ready) begin
                    if (out_last_q) begin
                        state_d     = HUNT;
                        out_valid_d = 1'b0;
                        out_data_d  = 8'h00;
                        out_last_d  = 1'b0;
                    end else begin
                        idx_d      = idx_q + 4'd1;
                        out_data_d = payload_q[{idx_d, 3'b000} +: 8];
                        out_last_d = (idx_d == 4'd15);
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            fill_q      <= 5'd0;
            wen_d_q     <= 1'b0;
            idx_q       <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            wen_d_q     <= wen_d_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // NOTE: the payload store has no reset; it is only read in SEND, which always follows a fresh load.
    always_ff @(posedge clk) begin
        payload_q <= payload_d;
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_last  = out_last_q;
    assign frame_ok         = frame_ok_q;
    assign frame_err        = frame_err_q;
    assign err_cnt          = err_cnt_q;
endmodule

// File: tb/tb_frame_parser.sv
// Directed/randomized bench for frame_parser against a byte-stream reference model.
// Honours FRAME_PARSER_CSUM_EN the same way as the design.
module tb_frame_parser;
`ifdef FRAME_PARSER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wen;
    logic [7:0]   wbyte;
    logic [151:0] frame;
    logic         frame_ok;
    logic         frame_err;
    logic [7:0]   err_cnt;

    frame_parser_if out_if ();

    frame_parser dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wen       (wen),
        .frame     (frame),
        .out_if    (out_if),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // External shift buffer: newest byte enters at byte 18.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame <= '0;
        else if (wen) frame <= {wbyte, frame[151:8]};
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: records handshaken bytes, counts pulses, checks data holds while stalled.
    logic [8:0] got_q[$];
    int         ok_seen;
    int         err_seen;
    logic       stall_pend;
    logic [8:0] stall_val;

    always @(negedge clk) begin
        if (!rst_n) begin
            got_q.delete();
            ok_seen    = 0;
            err_seen   = 0;
            stall_pend = 1'b0;
        end else begin
            if (stall_pend && out_if.out_valid)
                check("stall_hold", {23'd0, out_if.out_last, out_if.out_data}, {23'd0, stall_val});
            stall_pend = out_if.out_valid && !out_if.out_ready;
            stall_val  = {out_if.out_last, out_if.out_data};
            if (out_if.out_valid && out_if.out_ready) got_q.push_back({out_if.out_last, out_if.out_data});
            if (frame_ok)  ok_seen++;
            if (frame_err) err_seen++;
        end
    end

    // Reference model: works on the written byte stream, no notion of RTL state encoding.
    logic [7:0] m_win[$];
    int         m_fill, m_ok, m_errp, m_err;
    logic [8:0] exp_q[$];

    task automatic model_reset();
        m_win.delete();
        exp_q.delete();
        m_fill = 0; m_ok = 0; m_errp = 0; m_err = 0;
    endtask

    task automatic model_write(input logic [7:0] b);
        logic [7:0] s;
        m_win.push_back(b);
        if (m_win.size() > 19) void'(m_win.pop_front());
        if (m_fill < 19) m_fill++;
        if (m_fill == 19 && m_win[0] == 8'hA5 && m_win[1] == 8'h5A) begin
            s = 8'h00;
            for (int i = 2; i < 18; i++) s = s + m_win[i];
            if (!CSUM_EN || s == m_win[18]) begin
                for (int i = 2; i < 18; i++) exp_q.push_back({(i == 17), m_win[i]});
                m_ok++;
                m_fill = 0;
            end else begin
                m_errp++;
                if (m_err < 255) m_err++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        wen   = 1'b1;
        wbyte = b;
        model_write(b);
        tick();
        wen   = 1'b0;
    endtask

    task automatic build_frame(input logic [7:0] pl[16], input bit bad, output logic [7:0] fb[19]);
        logic [7:0] s;
        s = 8'h00;
        fb[0] = 8'hA5;
        fb[1] = 8'h5A;
        for (int i = 0; i < 16; i++) begin
            fb[i+2] = pl[i];
            s = s + pl[i];
        end
        fb[18] = bad ? s + 8'd1 : s;
    endtask

    task automatic send(input logic [7:0] fb[19], input int first, input int last);
        for (int i = first; i <= last; i++) wr(fb[i]);
    endtask

    task automatic rand_payload(output logic [7:0] pl[16]);
        for (int i = 0; i < 16; i++) pl[i] = 8'($urandom) & 8'h7F;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && out_if.out_valid; i++) tick();
        check("drain_timeout", {31'd0, out_if.out_valid}, 32'd0);
        tick();
        tick();
    endtask

    task automatic compare_all(input string tag);
        int n;
        check({tag, "_bytes"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_data"}, {23'd0, got_q[i]}, {23'd0, exp_q[i]});
        check({tag, "_ok_pulses"},  ok_seen,  m_ok);
        check({tag, "_err_pulses"}, err_seen, m_errp);
        check({tag, "_err_cnt"},    {24'd0, err_cnt}, m_err);
        got_q.delete();
        exp_q.delete();
        ok_seen  = 0;
        err_seen = 0;
        m_ok     = 0;
        m_errp   = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, {31'd0, out_if.out_valid}, 32'd0);
        check({tag, "_data"},  {24'd0, out_if.out_data},  32'd0);
        check({tag, "_last"},  {31'd0, out_if.out_last},  32'd0);
        check({tag, "_ok"},    {31'd0, frame_ok},         32'd0);
        check({tag, "_err"},   {31'd0, frame_err},        32'd0);
        check({tag, "_cnt"},   {24'd0, err_cnt},          32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pl[16];
        logic [7:0] fb[19];
        logic [7:0] held;
        int n_bad;

        rst_n = 1'b0;
        wen   = 1'b0;
        wbyte = 8'h00;
        out_if.out_ready = 1'b1;
        #1;
        check_outputs_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();

        // Known-good frame A5 5A 01..10 88, with first-byte latency.
        for (int i = 0; i < 16; i++) pl[i] = 8'(i + 1);
        build_frame(pl, 1'b0, fb);
        send(fb, 0, 18);
        check("lat_valid_early", {31'd0, out_if.out_valid}, 32'd0);
        check("lat_ok_early",    {31'd0, frame_ok},         32'd0);
        tick();
        check("lat_ok",    {31'd0, frame_ok},         32'd1);
        check("lat_valid", {31'd0, out_if.out_valid}, 32'd1);
        check("lat_data",  {24'd0, out_if.out_data},  32'h01);
        drain();
        compare_all("good");

        // Same frame with checksum 89.
        build_frame(pl, 1'b1, fb);
        send(fb, 0, 18);
        tick();
        tick();
        drain();
        compare_all("badsum");

        // Random frame, consumer stalls five cycles mid-payload.
        rand_payload(pl);
        build_frame(pl, 1'b0, fb);
        send(fb, 0, 18);
        tick();
        for (int i = 0; i < 50 && got_q.size() < 6; i++) tick();
        out_if.out_ready = 1'b0;
        held = out_if.out_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", {31'd0, out_if.out_valid}, 32'd1);
            check("stall_data",  {24'd0, out_if.out_data},  {24'd0, held});
        end
        out_if.out_ready = 1'b1;
        drain();
        compare_all("stall");

        // Three junk bytes before a frame: acceptance only on the 22nd write.
        do_reset();
        rand_payload(pl);
        build_frame(pl, 1'b0, fb);
        for (int i = 0; i < 3; i++) wr(8'h00);
        send(fb, 0, 17);
        tick();
        tick();
        check("junk_no_ok_before_22", ok_seen, 0);
        send(fb, 18, 18);
        tick();
        check("junk_ok_at_22", {31'd0, frame_ok}, 32'd1);
        drain();
        compare_all("junk");

        // Eighteen bytes alone must not be accepted.
        do_reset();
        rand_payload(pl);
        build_frame(pl, 1'b0, fb);
        send(fb, 0, 17);
        tick();
        tick();
        tick();
        check("short_no_ok",    ok_seen, 0);
        check("short_no_valid", {31'd0, out_if.out_valid}, 32'd0);
        send(fb, 18, 18);
        tick();
        drain();
        compare_all("short_then_full");

        // Reset after the fourth payload handshake.
        rand_payload(pl);
        build_frame(pl, 1'b0, fb);
        send(fb, 0, 18);
        tick();
        for (int i = 0; i < 50 && got_q.size() < 4; i++) tick();
        check("pre_reset_handshakes", got_q.size(), 4);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midsend_reset");
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        check("no_resume_valid", {31'd0, out_if.out_valid}, 32'd0);
        rand_payload(pl);
        build_frame(pl, 1'b0, fb);
        send(fb, 0, 18);
        tick();
        drain();
        compare_all("after_reset");

        // Writes continue during SEND with ready toggling; payload must be unaffected.
        do_reset();
        rand_payload(pl);
        build_frame(pl, 1'b0, fb);
        send(fb, 0, 18);
        for (int i = 0; i < 10; i++) begin
            wen   = 1'b1;
            wbyte = 8'($urandom) & 8'h7F;
            out_if.out_ready = 1'($urandom);
            tick();
        end
        wen = 1'b0;
        for (int i = 0; i < 300 && out_if.out_valid; i++) begin
            out_if.out_ready = 1'($urandom);
            tick();
        end
        out_if.out_ready = 1'b1;
        drain();
        compare_all("busy_writes");

        // Repeated bad-checksum frames: error count saturates.
        do_reset();
        for (int i = 0; i < 16; i++) pl[i] = 8'(i + 1);
        build_frame(pl, 1'b1, fb);
        n_bad = CSUM_EN ? 256 : 3;
        for (int k = 0; k < n_bad; k++) begin
            send(fb, 0, 18);
            tick();
            tick();
            if (!CSUM_EN) drain();
            check("sat_err_cnt", {24'd0, err_cnt}, m_err);
        end
        check("sat_final", {24'd0, err_cnt}, CSUM_EN ? 32'hFF : 32'h0);
        compare_all("saturate");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
